ev_dispatcher: RTL and testbench

EV_DISPATCHER -- requirements
Module: ev_dispatcher

---
 rtl/ev_pkg.sv | 44 ++++
 rtl/ev_req_slot.sv | 57 +++++
 rtl/ev_dispatcher.sv | 206 ++++++++++++++++++++
 tb/tb_ev_dispatcher.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ev_pkg.sv
// Shared types and helpers for the elevator dispatcher.
// Optional trip statistics are enabled by defining EV_DISPATCH_STATS_EN.
package ev_pkg;

  typedef enum logic [1:0] {
    CAR_IDLE,
    CAR_MOVE_UP,
    CAR_MOVE_DOWN,
    CAR_DOOR_OPEN
  } car_state_e;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_WAITING,
    SLOT_ONBOARD
  } slot_state_e;

  localparam logic [1:0] UPDOWN_STOP = 2'b00;
  localparam logic [1:0] UPDOWN_UP   = 2'b01;
  localparam logic [1:0] UPDOWN_DOWN = 2'b10;

  // Direction choice when no target is at the current floor; pref_up breaks ties.
  function automatic car_state_e pick_dir(input logic pref_up, input logic above,
                                          input logic below);
    car_state_e s;
    s = CAR_IDLE;
    if (pref_up) begin
      if (above)      s = CAR_MOVE_UP;
      else if (below) s = CAR_MOVE_DOWN;
    end else begin
      if (below)      s = CAR_MOVE_DOWN;
      else if (above) s = CAR_MOVE_UP;
    end
    return s;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/ev_req_slot.sv
// One passenger request slot: holds src/dest and performs boarding/alighting.
module ev_req_slot
  import ev_pkg::*;
#(
  parameter int unsigned FLOOR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FLOOR_W-1:0] load_src,
  input  logic [FLOOR_W-1:0] load_dest,
  input  logic               door_open,
  input  logic [FLOOR_W-1:0] floor,
  output logic               free_c,
  output logic               has_tgt_c,
  output logic [FLOOR_W-1:0] tgt_c,
  output logic               board_c,
  output logic               alight_c
);

  slot_state_e        state_q, state_d;
  logic [FLOOR_W-1:0] src_q, src_d, dest_q, dest_d;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dest_d    = dest_q;
    free_c    = (state_q == SLOT_FREE);
    has_tgt_c = (state_q != SLOT_FREE);
    tgt_c     = (state_q == SLOT_ONBOARD) ? dest_q : src_q;
    board_c   = door_open && (state_q == SLOT_WAITING) && (src_q == floor);
    alight_c  = door_open && (state_q == SLOT_ONBOARD) && (dest_q == floor);
    // A slot is in exactly one state, so it can never board and alight together.
    if (board_c) begin
      state_d = SLOT_ONBOARD;
    end else if (alight_c) begin
      state_d = SLOT_FREE;
    end else if (load && free_c) begin
      state_d = SLOT_WAITING;
      src_d   = load_src;
      dest_d  = load_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_FREE;
      src_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dest_q  <= dest_d;
    end
  end

endmodule

// File: rtl/ev_dispatcher.sv
// Single-car elevator dispatcher: request slots plus a car movement/door FSM.
// Define EV_DISPATCH_STATS_EN to add the saturating stat_trips counter port.
module ev_dispatcher
  import ev_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned NUM_SLOTS     = 4,
  parameter int unsigned TRAVEL_CYCLES = 2,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FLOOR_W-1:0]   req_src,
  input  logic [FLOOR_W-1:0]   req_dest,
  input  logic                 req_dir,
  output logic                 req_err,
  output logic [FLOOR_W-1:0]   ev_floor,
  output logic                 ev_door,
  output logic [1:0]           ev_updown,
  output logic [NUM_SLOTS-1:0] done_mask
`ifdef EV_DISPATCH_STATS_EN
  ,
  output logic [15:0]          stat_trips
`endif
);

  localparam int unsigned FW1    = FLOOR_W + 1;
  localparam int unsigned DOOR_W = $clog2(DOOR_CYCLES + 1);
  localparam int unsigned TRAV_W = $clog2(TRAVEL_CYCLES + 1);

  car_state_e          state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d, ref_floor;
  logic                dir_up_q, dir_up_d;
  logic [DOOR_W-1:0]   door_cnt_q, door_cnt_d;
  logic [TRAV_W-1:0]   trav_q, trav_d;
  logic                ev_door_q;
  logic [1:0]          updown_q, updown_d;
  logic                req_err_q;
  logic [NUM_SLOTS-1:0] done_q;

  logic [NUM_SLOTS-1:0] free_vec, has_tgt_vec, board_vec, alight_vec, load_vec;
  logic [FLOOR_W-1:0]   tgt_arr [NUM_SLOTS];
  logic                 illegal_c, accept_c, door_open_c, hold_c, found;
  logic                 step, any_at, any_above, any_below;

  assign illegal_c = (req_src == req_dest)
                  || ({1'b0, req_src}  >= FW1'(NUM_FLOORS))
                  || ({1'b0, req_dest} >= FW1'(NUM_FLOORS))
                  || (req_dir != (req_dest > req_src));
  assign req_ready   = |free_vec;
  assign accept_c    = req_valid && req_ready && !illegal_c;
  assign door_open_c = (state_q == CAR_DOOR_OPEN);
  // A passenger arriving at the open door keeps it open so they board next cycle.
  assign hold_c      = accept_c && door_open_c && (req_src == floor_q);

  always_comb begin
    load_vec = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (accept_c && free_vec[i] && !found) begin
        load_vec[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    ev_req_slot #(.FLOOR_W(FLOOR_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_vec[g]),
      .load_src  (req_src),
      .load_dest (req_dest),
      .door_open (door_open_c),
      .floor     (floor_q),
      .free_c    (free_vec[g]),
      .has_tgt_c (has_tgt_vec[g]),
      .tgt_c     (tgt_arr[g]),
      .board_c   (board_vec[g]),
      .alight_c  (alight_vec[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    door_cnt_d = door_cnt_q;
    trav_d     = trav_q;
    updown_d   = UPDOWN_STOP;
    step       = 1'b0;
    ref_floor  = floor_q;
    any_at     = 1'b0;
    any_above  = 1'b0;
    any_below  = 1'b0;

    // Targets are judged against the floor the car is about to occupy.
    if ((state_q == CAR_MOVE_UP || state_q == CAR_MOVE_DOWN) &&
        trav_q == TRAV_W'(TRAVEL_CYCLES - 1)) begin
      step = 1'b1;
      if (state_q == CAR_MOVE_UP && floor_q < FLOOR_W'(NUM_FLOORS - 1))
        ref_floor = floor_q + FLOOR_W'(1);
      else if (state_q == CAR_MOVE_DOWN && floor_q != '0)
        ref_floor = floor_q - FLOOR_W'(1);
    end

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (has_tgt_vec[i]) begin
        if (tgt_arr[i] == ref_floor)     any_at    = 1'b1;
        else if (tgt_arr[i] > ref_floor) any_above = 1'b1;
        else                             any_below = 1'b1;
      end
    end

    case (state_q)
      CAR_IDLE: begin
        if (any_at) state_d = CAR_DOOR_OPEN;
        else        state_d = pick_dir(1'b1, any_above, any_below);
      end
      CAR_MOVE_UP, CAR_MOVE_DOWN: begin
        if (step) begin
          floor_d = ref_floor;
          if (any_at) state_d = CAR_DOOR_OPEN;
          else        state_d = pick_dir(dir_up_q, any_above, any_below);
        end
      end
      CAR_DOOR_OPEN: begin
        if ((|board_vec) || (|alight_vec) || hold_c) begin
          door_cnt_d = DOOR_W'(DOOR_CYCLES);
        end else if (door_cnt_q > DOOR_W'(1)) begin
          door_cnt_d = door_cnt_q - DOOR_W'(1);
        end else begin
          door_cnt_d = '0;
          state_d    = pick_dir(dir_up_q, any_above, any_below);
        end
      end
      default: state_d = CAR_IDLE;
    endcase

    // Travel timer restarts on every floor step and on every state change.
    if (step || state_d != state_q) trav_d = '0;
    else if (state_q == CAR_MOVE_UP || state_q == CAR_MOVE_DOWN)
      trav_d = trav_q + TRAV_W'(1);

    if (state_d == CAR_DOOR_OPEN && state_q != CAR_DOOR_OPEN)
      door_cnt_d = DOOR_W'(DOOR_CYCLES);
    if (state_d == CAR_MOVE_UP) begin
      dir_up_d = 1'b1;
      updown_d = UPDOWN_UP;
    end else if (state_d == CAR_MOVE_DOWN) begin
      dir_up_d = 1'b0;
      updown_d = UPDOWN_DOWN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CAR_IDLE;
      floor_q    <= '0;
      dir_up_q   <= 1'b1;
      door_cnt_q <= '0;
      trav_q     <= '0;
      ev_door_q  <= 1'b0;
      updown_q   <= UPDOWN_STOP;
      req_err_q  <= 1'b0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_up_q   <= dir_up_d;
      door_cnt_q <= door_cnt_d;
      trav_q     <= trav_d;
      ev_door_q  <= (state_d == CAR_DOOR_OPEN);
      updown_q   <= updown_d;
      req_err_q  <= req_valid && illegal_c;
      done_q     <= alight_vec;
    end
  end

  assign ev_floor  = floor_q;
  assign ev_door   = ev_door_q;
  assign ev_updown = updown_q;
  assign req_err   = req_err_q;
  assign done_mask = done_q;

`ifdef EV_DISPATCH_STATS_EN
  logic [15:0] stat_q, stat_d;
  logic [16:0] stat_sum;

  always_comb begin
    stat_sum = 17'(stat_q) + 17'(popcount8(8'(alight_vec)));
    stat_d   = stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_trips = stat_q;
`endif

endmodule

// File: tb/tb_ev_dispatcher.sv
// Directed self-checking bench for ev_dispatcher (FLOOR_W widened to 4 so
// out-of-range floors such as 9 can be presented).
module tb_ev_dispatcher;

  localparam int unsigned FW = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned TC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [FW-1:0] req_src = '0;
  logic [FW-1:0] req_dest = '0;
  logic          req_dir = 1'b0;
  logic          req_err;
  logic [FW-1:0] ev_floor;
  logic          ev_door;
  logic [1:0]    ev_updown;
  logic [NS-1:0] done_mask;
`ifdef EV_DISPATCH_STATS_EN
  logic [15:0]   stat_trips;
`endif

  int n_vec = 0;
  int n_miss = 0;
  int stops[$];
  int done_cnt = 0;
  int ready_low = 0;
  logic door_prev = 1'b0;

  ev_dispatcher #(
    .NUM_FLOORS(8), .FLOOR_W(FW), .NUM_SLOTS(NS), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dest  (req_dest),
    .req_dir   (req_dir),
    .req_err   (req_err),
    .ev_floor  (ev_floor),
    .ev_door   (ev_door),
    .ev_updown (ev_updown),
    .done_mask (done_mask)
`ifdef EV_DISPATCH_STATS_EN
    ,
    .stat_trips(stat_trips)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ev_door && !door_prev) stops.push_back(int'(ev_floor));
    door_prev = ev_door;
    if (done_mask != '0) done_cnt++;
    if (rst_n && !req_ready) ready_low++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    stops.delete();
    done_cnt = 0;
    ready_low = 0;
  endtask

  task automatic send(input int s, input int d, input logic dir);
    req_valid = 1'b1;
    req_src   = FW'(s);
    req_dest  = FW'(d);
    req_dir   = dir;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // kind: 0 done pulse, 1 door open, 2 moving up, 3 moving up at floor 3
  task automatic wait_cond(input int kind, input int budget, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      case (kind)
        0: hit = (done_mask != '0);
        1: hit = ev_door;
        2: hit = (ev_updown == 2'b01);
        default: hit = (ev_floor == FW'(3)) && (ev_updown == 2'b01);
      endcase
    end
    if (!hit) chk($sformatf("timeout_kind%0d", kind), 32'd0, 32'd1);
  endtask

  initial begin
    int c;
    do_reset();
    chk("rst_floor", 32'(ev_floor), 0);
    chk("rst_door", 32'(ev_door), 0);
    chk("rst_updown", 32'(ev_updown), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_done", 32'(done_mask), 0);

    // single trip 0 -> 5
    send(0, 5, 1'b1);
    wait_cond(2, 100, c);
    wait_cond(1, 100, c);
    chk("t1_travel", 32'(c), 32'(5 * TC));
    chk("t1_arr_floor", 32'(ev_floor), 5);
    wait_cond(0, 50, c);
    chk("t1_done", 32'(done_mask), 32'b0001);
    chk("t1_nstops", 32'(stops.size()), 2);
    if (stops.size() == 2) begin
      chk("t1_stop0", 32'(stops[0]), 0);
      chk("t1_stop1", 32'(stops[1]), 5);
    end
    chk("t1_ready_low", 32'(ready_low), 0);

    // two overlapping up trips from floor 0
    do_reset();
    send(1, 6, 1'b1);
    send(3, 4, 1'b1);
    wait_cond(0, 200, c);
    chk("t2_done_a", 32'(done_mask), 32'b0010);
    chk("t2_floor_a", 32'(ev_floor), 4);
    wait_cond(0, 200, c);
    chk("t2_done_b", 32'(done_mask), 32'b0001);
    chk("t2_floor_b", 32'(ev_floor), 6);
    chk("t2_nstops", 32'(stops.size()), 4);
    if (stops.size() == 4) begin
      chk("t2_stop0", 32'(stops[0]), 1);
      chk("t2_stop1", 32'(stops[1]), 3);
      chk("t2_stop2", 32'(stops[2]), 4);
      chk("t2_stop3", 32'(stops[3]), 6);
    end

    // illegal requests
    do_reset();
    send(2, 2, 1'b1);
    chk("t3_err_same", 32'(req_err), 1);
    send(4, 1, 1'b1);
    chk("t3_err_dir", 32'(req_err), 1);
    send(9, 3, 1'b0);
    chk("t3_err_range", 32'(req_err), 1);
    send(2, 8, 1'b1);
    chk("t3_err_dest", 32'(req_err), 1);
    @(posedge clk); #1;
    chk("t3_err_clear", 32'(req_err), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_ready", 32'(req_ready), 1);
    chk("t3_idle_door", 32'(ev_door), 0);
    chk("t3_idle_updown", 32'(ev_updown), 0);
    chk("t3_stops", 32'(stops.size()), 0);

    // fill every slot, reject overflow
    do_reset();
    send(0, 1, 1'b1);
    send(0, 2, 1'b1);
    send(0, 3, 1'b1);
    chk("t4_ready_partial", 32'(req_ready), 1);
    send(0, 4, 1'b1);
    chk("t4_ready_full", 32'(req_ready), 0);
    send(0, 7, 1'b1);
    chk("t4_overflow_err", 32'(req_err), 0);
    send(5, 5, 1'b1);
    chk("t4_err_when_full", 32'(req_err), 1);
    chk("t4_still_full", 32'(req_ready), 0);
    wait_cond(0, 200, c);
    chk("t4_done0", 32'(done_mask), 32'b0001);
    chk("t4_ready_back", 32'(req_ready), 1);
    wait_cond(0, 200, c);
    chk("t4_done1", 32'(done_mask), 32'b0010);
    wait_cond(0, 200, c);
    chk("t4_done2", 32'(done_mask), 32'b0100);
    wait_cond(0, 200, c);
    chk("t4_done3", 32'(done_mask), 32'b1000);
    repeat (30) @(posedge clk);
    #1;
    chk("t4_final_floor", 32'(ev_floor), 4);
    chk("t4_final_door", 32'(ev_door), 0);
    chk("t4_final_updown", 32'(ev_updown), 0);

    // reset while moving up at floor 3
    do_reset();
    send(0, 6, 1'b1);
    wait_cond(3, 200, c);
    rst_n = 1'b0;
    #1;
    chk("t5_floor", 32'(ev_floor), 0);
    chk("t5_door", 32'(ev_door), 0);
    chk("t5_updown", 32'(ev_updown), 0);
    chk("t5_err", 32'(req_err), 0);
    chk("t5_ready", 32'(req_ready), 1);
    chk("t5_done", 32'(done_mask), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t5_stay_floor", 32'(ev_floor), 0);
    chk("t5_no_done", 32'(done_cnt), 0);

`ifdef EV_DISPATCH_STATS_EN
    // two passengers alighting together
    do_reset();
    chk("t6_stat_rst", 32'(stat_trips), 0);
    send(0, 3, 1'b1);
    send(0, 3, 1'b1);
    wait_cond(0, 200, c);
    chk("t6_done", 32'(done_mask), 32'b0011);
    chk("t6_stat", 32'(stat_trips), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
